// File: rtl/hdmi_tx_pkg.sv
// Shared register map, bit positions and helpers for the HDMI pixel streamer.
// Imported by the FIFO and by the top level.
package hdmi_tx_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_FLUSH_BIT     = 1;
    localparam int unsigned STAT_LEVEL_MSB     = 7;
    localparam int unsigned STAT_UNDERFLOW_BIT = 8;
    localparam int unsigned STAT_OVERFLOW_BIT  = 9;
    localparam int unsigned STAT_VSYNC_BIT     = 10;

    localparam logic [23:0] BLANK_RGB = 24'h000000;

    typedef logic [15:0] cnt_t;

    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/hdmi_tx_pixel_stream_if.sv
// Avalon-MM register port of the HDMI pixel streamer.
interface hdmi_tx_pixel_stream_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hdmi_tx_pixel_fifo.sv
// First-word-fall-through pixel FIFO; flush beats push, a pop frees room for a same-cycle push.
module hdmi_tx_pixel_fifo
    import hdmi_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [23:0] data_i,
    output logic [23:0] data_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [7:0]  level_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);
    assign data_o  = empty_o ? BLANK_RGB : mem_q[rd_ptr_q];
    assign level_o = 8'(count_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/hdmi_tx_pixel_stream.sv
// HDMI/VGA timing generator fed by an Avalon-MM pixel FIFO; video outputs lag the counters by one clock.
module hdmi_tx_pixel_stream
    import hdmi_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hdmi_tx_pixel_stream_if.slave  avs,
    output logic [23:0]            hdmi_tx_d,
    output logic                   hdmi_tx_de,
    output logic                   hdmi_tx_hs,
    output logic                   hdmi_tx_vs
);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    reg_addr_e   addr;
    logic        wr_en, wr_data, wr_ctrl, wr_status, flush;
    logic        enable_q, enable_d;
    logic        underflow_q, underflow_d;
    logic        overflow_q, overflow_d;
    cnt_t        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [23:0] d_q, d_d;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic        pix_active, in_hsync, in_vsync;
    logic        fifo_full, fifo_empty;
    logic [23:0] fifo_data;
    logic [7:0]  fifo_level;
    logic        unused_wdata;

    assign addr      = reg_addr_e'(avs.address);
    assign wr_en     = avs.chipselect && !avs.write_n;
    assign wr_data   = wr_en && (addr == REG_DATA);
    assign wr_ctrl   = wr_en && (addr == REG_CTRL);
    assign wr_status = wr_en && (addr == REG_STATUS);
    assign flush     = wr_ctrl && avs.writedata[CTRL_FLUSH_BIT];
    assign unused_wdata = ^avs.writedata[31:24];

    assign pix_active = enable_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign in_hsync   = enable_q && in_window(h_cnt_q, HS_START, HS_END);
    assign in_vsync   = enable_q && in_window(v_cnt_q, VS_START, VS_END);

    hdmi_tx_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (wr_data),
        .pop_i   (pix_active),
        .flush_i (flush),
        .data_i  (avs.writedata[23:0]),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Counters only advance while enable stays set across the edge, so both enabling and disabling land on 0/0.
    always_comb begin
        enable_d = wr_ctrl ? avs.writedata[CTRL_ENABLE_BIT] : enable_q;
        h_cnt_d  = '0;
        v_cnt_d  = '0;
        if (enable_q && enable_d) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
            end else begin
                h_cnt_d = h_cnt_q + 16'd1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // A set event in the same cycle as a clear wins, so no underflow/overflow is lost.
    always_comb begin
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        if (wr_status && avs.writedata[STAT_UNDERFLOW_BIT]) underflow_d = 1'b0;
        if (wr_status && avs.writedata[STAT_OVERFLOW_BIT])  overflow_d  = 1'b0;
        if (pix_active && fifo_empty)                      underflow_d = 1'b1;
        if (wr_data && fifo_full && !pix_active)           overflow_d  = 1'b1;
    end

    always_comb begin
        de_d = pix_active;
        d_d  = pix_active ? fifo_data : BLANK_RGB;
        hs_d = !in_hsync;
        vs_d = !in_vsync;
    end

    always_comb begin
        avs.readdata = '0;
        case (addr)
            REG_CTRL: avs.readdata[CTRL_ENABLE_BIT] = enable_q;
            REG_STATUS: begin
                avs.readdata[STAT_LEVEL_MSB:0]     = fifo_level;
                avs.readdata[STAT_UNDERFLOW_BIT]   = underflow_q;
                avs.readdata[STAT_OVERFLOW_BIT]    = overflow_q;
                avs.readdata[STAT_VSYNC_BIT]       = in_vsync;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q    <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            d_q         <= BLANK_RGB;
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            enable_q    <= enable_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            d_q         <= d_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign hdmi_tx_d  = d_q;
    assign hdmi_tx_de = de_q;
    assign hdmi_tx_hs = hs_q;
    assign hdmi_tx_vs = vs_q;

endmodule

// File: tb/tb_hdmi_tx_pixel_stream.sv
// Bench for hdmi_tx_pixel_stream: directed scenarios plus random bus traffic against a
// frame-position/queue reference model, with every video cycle and register read compared.
module tb_hdmi_tx_pixel_stream;

    localparam int HA = 4, HT = 8, HSS = 5, HSE = 7;
    localparam int VA = 2, VT = 5, VSS = 3, VSE = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] hdmi_tx_d;
    logic        hdmi_tx_de, hdmi_tx_hs, hdmi_tx_vs;

    hdmi_tx_pixel_stream_if bus ();

    hdmi_tx_pixel_stream #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (bus),
        .hdmi_tx_d  (hdmi_tx_d),
        .hdmi_tx_de (hdmi_tx_de),
        .hdmi_tx_hs (hdmi_tx_hs),
        .hdmi_tx_vs (hdmi_tx_vs)
    );

    always #5 clk = ~clk;

    // Reference model: pixel position since enable, a queue of pending pixels, sticky flags.
    logic [23:0] q[$];
    bit          en, uf, of;
    int          pos;
    logic [26:0] exp_vid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void m_reset();
        q.delete();
        en = 0; uf = 0; of = 0; pos = 0;
        exp_vid = {1'b0, 1'b1, 1'b1, 24'h0};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int v;
        v = (pos / HT) % VT;
        s = '0;
        s[7:0] = 8'(q.size());
        s[8]   = uf;
        s[9]   = of;
        s[10]  = en && (v >= VSS) && (v < VSE);
        return s;
    endfunction

    task automatic step(input bit wr, input logic [1:0] a, input logic [31:0] wd);
        int h, v, pre;
        bit act, popped, en_next;
        logic [23:0] px;
        bus.chipselect = wr;
        bus.write_n    = ~wr;
        bus.address    = a;
        bus.writedata  = wd;
        h = pos % HT;
        v = (pos / HT) % VT;
        act = en && (h < HA) && (v < VA);
        pre = q.size();
        popped = 0;
        px = '0;
        if (wr && a == 2'd2) begin
            if (wd[8]) uf = 0;
            if (wd[9]) of = 0;
        end
        if (act) begin
            if (pre > 0) begin px = q.pop_front(); popped = 1; end
            else uf = 1;
        end
        exp_vid = {act, !(en && h >= HSS && h < HSE), !(en && v >= VSS && v < VSE), px};
        en_next = en;
        if (wr && a == 2'd0) begin
            if (pre == DEPTH && !popped) of = 1;
            else q.push_back(wd[23:0]);
        end
        if (wr && a == 2'd1) begin
            en_next = wd[0];
            if (wd[1]) q.delete();
        end
        pos = (en && en_next) ? pos + 1 : 0;
        en  = en_next;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        check("video", {5'b0, hdmi_tx_de, hdmi_tx_hs, hdmi_tx_vs, hdmi_tx_d}, {5'b0, exp_vid});
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        #1;
        check(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic rd_any();
        int unsigned a;
        a = $urandom_range(3, 1);
        case (a)
            1: rd(2'd1, {31'b0, en}, "rd_ctrl");
            2: rd(2'd2, exp_status(), "rd_status");
            default: rd(2'd3, 32'h0, "rd_rsvd");
        endcase
    endtask

    initial begin
        reset_n = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_video", {5'b0, hdmi_tx_de, hdmi_tx_hs, hdmi_tx_vs, hdmi_tx_d}, {5'b0, exp_vid});
        rd(2'd2, 32'h0, "rst_status");
        rd(2'd1, 32'h0, "rst_ctrl");
        reset_n = 1'b1;

        // Ordered stream of 1..8, refilled while the first line drains.
        for (int i = 1; i <= 4; i++) step(1, 2'd0, i);
        step(1, 2'd1, 32'h1);
        for (int i = 5; i <= 8; i++) step(1, 2'd0, i);
        repeat (14) step(0, 2'd0, 0);
        rd(2'd2, exp_status(), "stream_status");
        check("stream_drained", exp_status() & 32'h1FF, dut.avs.readdata & 32'h0);
        step(1, 2'd1, 32'h0);

        // Underflow on an empty FIFO, then clear it.
        step(1, 2'd1, 32'h1);
        repeat (3) step(0, 2'd0, 0);
        rd(2'd2, exp_status(), "uf_set");
        step(1, 2'd1, 32'h0);
        step(1, 2'd2, 32'h100);
        rd(2'd2, exp_status(), "uf_clear");

        // Overflow while disabled, then a push accepted alongside a pop when full.
        for (int i = 0; i < 5; i++) step(1, 2'd0, $urandom);
        rd(2'd2, exp_status(), "of_set");
        step(1, 2'd2, 32'h200);
        step(1, 2'd1, 32'h1);
        step(1, 2'd0, $urandom);
        rd(2'd2, exp_status(), "full_pop_push");

        // A full frame of sync timing with STATUS sampled every cycle.
        for (int i = 0; i < 45; i++) begin
            if ($urandom_range(1) == 0) step(1, 2'd0, $urandom);
            else step(0, 2'd0, 0);
            rd(2'd2, exp_status(), "frame_status");
        end

        // Disable mid-line and restart.
        repeat (5) step(0, 2'd0, 0);
        step(1, 2'd1, 32'h0);
        repeat (3) step(0, 2'd0, 0);
        rd(2'd1, {31'b0, en}, "disabled_ctrl");
        step(1, 2'd1, 32'h1);
        repeat (12) step(0, 2'd0, 0);

        // Random bus traffic.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(99);
            if (r < 40)      step(0, 2'd0, 0);
            else if (r < 75) step(1, 2'd0, $urandom);
            else if (r < 85) step(1, 2'd1, {$urandom_range(255), 22'b0,
                                             ($urandom_range(9) == 0) ? 1'b1 : 1'b0,
                                             ($urandom_range(4) != 0) ? 1'b1 : 1'b0});
            else if (r < 93) step(1, 2'd2, $urandom);
            else             step(1, 2'd3, $urandom);
            if ($urandom_range(3) == 0) rd_any();
        end

        // Asynchronous reset mid-frame with three pixels queued.
        step(1, 2'd1, 32'h2);
        step(1, 2'd1, 32'h1);
        repeat (20) step(0, 2'd0, 0);
        for (int i = 0; i < 3; i++) step(1, 2'd0, $urandom);
        step(0, 2'd0, 0);
        rd(2'd2, exp_status(), "pre_reset_status");
        reset_n = 1'b0;
        m_reset();
        #1;
        check("async_rst_video", {5'b0, hdmi_tx_de, hdmi_tx_hs, hdmi_tx_vs, hdmi_tx_d}, {5'b0, exp_vid});
        rd(2'd2, 32'h0, "async_rst_status");
        rd(2'd1, 32'h0, "async_rst_ctrl");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1, 2'd0, 32'h00ABCDEF);
        step(1, 2'd1, 32'h1);
        repeat (6) step(0, 2'd0, 0);
        rd(2'd2, exp_status(), "post_reset_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
